// File: rtl/jlut_pkg.sv
// Shared types and constants for the jump-target table and its byte-stream loader.
// The boot table below is used only when JLUT_RESET_DEFAULTS_EN is defined.
package jlut_pkg;

  localparam int DEPTH = 32;
  localparam int TW    = 12;
  localparam int AW    = 5;

  localparam logic [2:0] HDR_MARKER = 3'b101;

  typedef enum logic [1:0] {
    S_HDR    = 2'd0,
    S_LO     = 2'd1,
    S_HI     = 2'd2,
    S_COMMIT = 2'd3
  } jl_state_t;

  localparam int BOOT_N = 17;

  localparam logic [TW-1:0] BOOT_TABLE [BOOT_N] = '{
    12'd74,  12'd80,  12'd10,  12'd8,   12'd57,  12'd81,
    12'd36,  12'd73,  12'd111, 12'd135, 12'd9,   12'd2,
    12'd44,  12'd53,  12'd79,  12'd103, 12'd130
  };

  // Entries past the end of the boot table come up as zero.
  function automatic logic [TW-1:0] boot_value(input int idx);
    boot_value = '0;
    if (idx >= 0 && idx < BOOT_N) boot_value = BOOT_TABLE[idx[4:0]];
  endfunction

endpackage

// File: rtl/jlut_regfile.sv
// Jump-target storage: async reset, one synchronous write port, one combinational read port.
// Reset contents come from the boot table when JLUT_RESET_DEFAULTS_EN is defined, else zero.
module jlut_regfile #(
  parameter int DEPTH = jlut_pkg::DEPTH,
  parameter int TW    = jlut_pkg::TW,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [TW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [TW-1:0] o_rdata
);

  logic [TW-1:0] r_mem [DEPTH];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
`ifdef JLUT_RESET_DEFAULTS_EN
        r_mem[i] <= jlut_pkg::boot_value(i);
`else
        r_mem[i] <= '0;
`endif
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // No write bypass: a read of the entry being written returns the old value.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/jump_table_loader.sv
// Runtime-writable branch-target table fed by a 3-byte record loader (HDR, LO, HI).
// Optional boot contents at reset are selected by JLUT_RESET_DEFAULTS_EN.
module jump_table_loader #(
  parameter int DEPTH = 32,
  parameter int TW    = 12,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Load_en,
  input  logic          In_valid,
  input  logic [7:0]    In_data,
  output logic          In_ready,
  input  logic [AW-1:0] Jptr,
  output logic [TW-1:0] Jump,
  output logic          Wr_pulse,
  output logic          Err,
  output logic [5:0]    Count,
  output logic [1:0]    Dbg_state
);

  // Handshake: a byte is consumed on a rising edge where In_valid and In_ready
  // are both 1; In_ready depends only on Load_en and the state, never on In_valid.
  jlut_pkg::jl_state_t r_state;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_lo;
  logic [3:0]    r_hi;
  logic          r_wr_pulse;
  logic          r_err;
  logic [5:0]    r_count;

  logic w_accept;
  logic w_we;

  assign In_ready = Load_en && (r_state != jlut_pkg::S_COMMIT);
  assign w_accept = In_valid && In_ready;
  assign w_we     = (r_state == jlut_pkg::S_COMMIT);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= jlut_pkg::S_HDR;
      r_idx      <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_wr_pulse <= 1'b0;
      r_err      <= 1'b0;
      r_count    <= '0;
    end else begin
      r_wr_pulse <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        jlut_pkg::S_HDR: begin
          if (w_accept) begin
            if (In_data[7:5] == jlut_pkg::HDR_MARKER) begin
              r_idx   <= In_data[AW-1:0];
              r_state <= jlut_pkg::S_LO;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        jlut_pkg::S_LO: begin
          if (w_accept) begin
            r_lo    <= In_data;
            r_state <= jlut_pkg::S_HI;
          end
        end
        jlut_pkg::S_HI: begin
          if (w_accept) begin
            // Wr_pulse is raised here so it lines up with the commit cycle.
            if (In_data[7:4] == 4'h0) begin
              r_hi       <= In_data[3:0];
              r_wr_pulse <= 1'b1;
              r_state    <= jlut_pkg::S_COMMIT;
            end else begin
              r_err   <= 1'b1;
              r_state <= jlut_pkg::S_HDR;
            end
          end
        end
        jlut_pkg::S_COMMIT: begin
          if (r_count != 6'h3f) r_count <= r_count + 6'd1;
          r_state <= jlut_pkg::S_HDR;
        end
        default: r_state <= jlut_pkg::S_HDR;
      endcase
    end
  end

  assign Wr_pulse  = r_wr_pulse;
  assign Err       = r_err;
  assign Count     = r_count;
  assign Dbg_state = r_state;

  jlut_regfile #(
    .DEPTH (DEPTH),
    .TW    (TW),
    .AW    (AW)
  ) u_regfile (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata ({r_hi, r_lo}),
    .i_raddr (Jptr),
    .o_rdata (Jump)
  );

endmodule

// File: tb/tb_jump_table_loader.sv
// Directed bench for jump_table_loader: reset contents, record loads, error paths,
// Load_en stalls, mid-record reset and Count saturation.
module tb_jump_table_loader;

  logic        Clk;
  logic        Reset_n;
  logic        Load_en;
  logic        In_valid;
  logic [7:0]  In_data;
  logic        In_ready;
  logic [4:0]  Jptr;
  logic [11:0] Jump;
  logic        Wr_pulse;
  logic        Err;
  logic [5:0]  Count;
  logic [1:0]  Dbg_state;

  int checks;
  int failures;

  localparam logic [1:0] ST_HDR    = 2'd0;
  localparam logic [1:0] ST_HI     = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  jump_table_loader dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Load_en   (Load_en),
    .In_valid  (In_valid),
    .In_data   (In_data),
    .In_ready  (In_ready),
    .Jptr      (Jptr),
    .Jump      (Jump),
    .Wr_pulse  (Wr_pulse),
    .Err       (Err),
    .Count     (Count),
    .Dbg_state (Dbg_state)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected table contents right after reset.
  function automatic logic [11:0] exp_default(input int i);
    exp_default = 12'd0;
`ifdef JLUT_RESET_DEFAULTS_EN
    case (i)
      0: exp_default = 12'd74;   1: exp_default = 12'd80;   2: exp_default = 12'd10;
      3: exp_default = 12'd8;    4: exp_default = 12'd57;   5: exp_default = 12'd81;
      6: exp_default = 12'd36;   7: exp_default = 12'd73;   8: exp_default = 12'd111;
      9: exp_default = 12'd135;  10: exp_default = 12'd9;   11: exp_default = 12'd2;
      12: exp_default = 12'd44;  13: exp_default = 12'd53;  14: exp_default = 12'd79;
      15: exp_default = 12'd103; 16: exp_default = 12'd130;
      default: exp_default = 12'd0;
    endcase
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    In_valid = 1'b1;
    In_data  = b;
    tick();
    In_valid = 1'b0;
  endtask

  task automatic peek(input logic [4:0] p, input logic [11:0] exp, input string tag);
    Jptr = p;
    #1;
    check(tag, {20'd0, Jump}, {20'd0, exp});
  endtask

  initial begin
    logic [11:0] t;
    checks   = 0;
    failures = 0;
    Reset_n  = 1'b0;
    Load_en  = 1'b0;
    In_valid = 1'b0;
    In_data  = 8'h00;
    Jptr     = 5'd0;
    #2;
    check("rst_count", {26'd0, Count}, 32'd0);
    check("rst_wr", {31'd0, Wr_pulse}, 32'd0);
    check("rst_err", {31'd0, Err}, 32'd0);
    check("rst_state", {30'd0, Dbg_state}, {30'd0, ST_HDR});
    check("rst_ready_off", {31'd0, In_ready}, 32'd0);
    Load_en = 1'b1;
    #1;
    check("rst_ready_on", {31'd0, In_ready}, 32'd1);
    for (int i = 0; i < 32; i++) peek(5'(i), exp_default(i), "rst_table");
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();

    // Record A3,34,01 -> table[3] = 0x134
    send(8'hA3);
    send(8'h34);
    send(8'h01);
    check("rec_wr_pulse", {31'd0, Wr_pulse}, 32'd1);
    check("rec_err_quiet", {31'd0, Err}, 32'd0);
    check("rec_commit_state", {30'd0, Dbg_state}, {30'd0, ST_COMMIT});
    check("rec_commit_ready", {31'd0, In_ready}, 32'd0);
    peek(5'd3, exp_default(3), "rec_no_bypass");
    tick();
    check("rec_wr_drop", {31'd0, Wr_pulse}, 32'd0);
    check("rec_count", {26'd0, Count}, 32'd1);
    peek(5'd3, 12'h134, "rec_jump3");

    // Bad header, then a good record to index 0
    send(8'h43);
    check("badhdr_err", {31'd0, Err}, 32'd1);
    check("badhdr_state", {30'd0, Dbg_state}, {30'd0, ST_HDR});
    send(8'hA0);
    check("badhdr_err_drop", {31'd0, Err}, 32'd0);
    send(8'hFF);
    send(8'h0F);
    check("rec0_wr", {31'd0, Wr_pulse}, 32'd1);
    tick();
    peek(5'd0, 12'hFFF, "rec0_jump0");
    check("rec0_count", {26'd0, Count}, 32'd2);

    // Bad HI byte: error, no write
    send(8'hA5);
    send(8'h12);
    send(8'h1F);
    check("badhi_err", {31'd0, Err}, 32'd1);
    check("badhi_wr", {31'd0, Wr_pulse}, 32'd0);
    check("badhi_state", {30'd0, Dbg_state}, {30'd0, ST_HDR});
    tick();
    check("badhi_count", {26'd0, Count}, 32'd2);
    peek(5'd5, exp_default(5), "badhi_jump5");

    // Load_en dropped between LO and HI
    send(8'hA7);
    send(8'hCD);
    Load_en  = 1'b0;
    In_valid = 1'b1;
    In_data  = 8'h0A;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("gap_ready", {31'd0, In_ready}, 32'd0);
      check("gap_state", {30'd0, Dbg_state}, {30'd0, ST_HI});
      tick();
    end
    In_valid = 1'b0;
    Load_en  = 1'b1;
    send(8'h0A);
    check("gap_wr", {31'd0, Wr_pulse}, 32'd1);
    tick();
    peek(5'd7, 12'hACD, "gap_jump7");
    check("gap_count", {26'd0, Count}, 32'd3);

    // Reset after the LO byte
    send(8'hA9);
    send(8'h55);
    #2;
    Reset_n = 1'b0;
    #1;
    check("midrst_state", {30'd0, Dbg_state}, {30'd0, ST_HDR});
    check("midrst_count", {26'd0, Count}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
    check("midrst_wr", {31'd0, Wr_pulse}, 32'd0);
    check("midrst_count2", {26'd0, Count}, 32'd0);
    peek(5'd9, exp_default(9), "midrst_jump9");
    peek(5'd3, exp_default(3), "midrst_jump3");

    // 64 overwriting records to index 31: Count saturates at 63
    t = 12'd0;
    for (int k = 1; k <= 64; k++) begin
      t = 12'((k * 37) & 12'hFFF);
      send(8'hBF);
      send(t[7:0]);
      send({4'h0, t[11:8]});
      tick();
      if (k == 63) check("sat_count63", {26'd0, Count}, 32'd63);
    end
    check("sat_count_hold", {26'd0, Count}, 32'd63);
    peek(5'd31, t, "sat_jump31");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
